// File: rtl/mii_pkg.sv
// Shared constants and types for the MII receive path: control codes,
// default word width, frame FSM states and the character classes.
package mii_pkg;

  localparam int         DEFAULT_DATA_WIDTH = 64;
  localparam logic [7:0] IDLE_CODE_DEF      = 8'h07;
  localparam logic [7:0] START_CODE_DEF     = 8'hFB;
  localparam logic [7:0] EOF_CODE_DEF       = 8'hFD;

  // Frame tracking states
  typedef enum logic {
    WAIT_START = 1'b0,
    IN_FRAME   = 1'b1
  } state_t;

  // Classification of one incoming word
  typedef enum logic [2:0] {
    CHAR_IDLE  = 3'd0,
    CHAR_START = 3'd1,
    CHAR_TERM  = 3'd2,
    CHAR_DATA  = 3'd3,
    CHAR_BAD   = 3'd4
  } char_t;

endpackage

// File: rtl/rx_char_decode.sv
// Combinational classifier: maps one MII word plus its control flag to a
// character class (IDLE, START, TERM, DATA or BAD).
module rx_char_decode
  import mii_pkg::*;
#(
  parameter int         DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter logic [7:0] IDLE_CODE  = IDLE_CODE_DEF,
  parameter logic [7:0] START_CODE = START_CODE_DEF,
  parameter logic [7:0] EOF_CODE   = EOF_CODE_DEF
) (
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_ctrl,
  output char_t                 char_class
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  // Lane masks used to exempt byte 0 (START) or the top byte (TERM)
  // from the "every other byte is idle" test.
  localparam logic [NUM_BYTES-1:0] FIRST_LANE = {{(NUM_BYTES-1){1'b0}}, 1'b1};
  localparam logic [NUM_BYTES-1:0] LAST_LANE  = {1'b1, {(NUM_BYTES-1){1'b0}}};

  logic [NUM_BYTES-1:0] lane_idle;
  logic                 all_idle;
  logic                 start_word;
  logic                 term_word;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
      assign lane_idle[gi] = (rx_data[gi*8 +: 8] == IDLE_CODE);
    end
  endgenerate

  assign all_idle   = &lane_idle;
  assign start_word = (rx_data[7:0] == START_CODE) && (&(lane_idle | FIRST_LANE));
  assign term_word  = (rx_data[DATA_WIDTH-1 -: 8] == EOF_CODE) && (&(lane_idle | LAST_LANE));

  // Priority: data flag first, then the three legal control patterns
  always_comb begin
    char_class = CHAR_BAD;
    if (!rx_ctrl) begin
      char_class = CHAR_DATA;
    end else if (all_idle) begin
      char_class = CHAR_IDLE;
    end else if (start_word) begin
      char_class = CHAR_START;
    end else if (term_word) begin
      char_class = CHAR_TERM;
    end
  end

endmodule

// File: rtl/rx_frame_checker.sv
// Receive frame checker: tracks START/TERM framing on an MII word stream,
// delays payload by one hold word so the final word can be tagged o_last,
// and keeps saturating good-frame, error and frame-length counters.
module rx_frame_checker
  import mii_pkg::*;
#(
  parameter int         DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter logic [7:0] IDLE_CODE  = IDLE_CODE_DEF,
  parameter logic [7:0] START_CODE = START_CODE_DEF,
  parameter logic [7:0] EOF_CODE   = EOF_CODE_DEF,
  parameter int         CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_ctrl,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_sof,
  output logic                  o_last,
  output logic                  o_err,
  output logic [CNT_WIDTH-1:0]  o_frame_cnt,
  output logic [CNT_WIDTH-1:0]  o_err_cnt,
  output logic [CNT_WIDTH-1:0]  o_frame_len
);

  char_t                 char_class;
  state_t                state_reg;

  logic [DATA_WIDTH-1:0] hold_data_reg;
  logic                  hold_valid_reg;
  logic                  hold_sof_reg;
  logic                  sof_pending_reg;
  logic [CNT_WIDTH-1:0]  word_cnt_reg;

  // Per-cycle events derived from state and the current word
  logic emit;
  logic emit_last;
  logic emit_err;
  logic err_inc;
  logic frame_done;

  rx_char_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDLE_CODE  (IDLE_CODE),
    .START_CODE (START_CODE),
    .EOF_CODE   (EOF_CODE)
  ) u_decode (
    .rx_data    (i_rx_data),
    .rx_ctrl    (i_rx_ctrl),
    .char_class (char_class)
  );

  // Decide what the current word does to the held word and the counters
  always_comb begin
    emit       = 1'b0;
    emit_last  = 1'b0;
    emit_err   = 1'b0;
    err_inc    = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      WAIT_START: begin
        // Stray terminators and garbage outside a frame are protocol errors;
        // stray data is silently dropped.
        if (char_class == CHAR_TERM || char_class == CHAR_BAD) begin
          err_inc = 1'b1;
        end
      end
      IN_FRAME: begin
        case (char_class)
          CHAR_DATA: begin
            emit = hold_valid_reg;
          end
          CHAR_TERM: begin
            if (hold_valid_reg) begin
              emit       = 1'b1;
              emit_last  = 1'b1;
              frame_done = 1'b1;
            end else begin
              // START immediately followed by TERM: empty frame
              err_inc = 1'b1;
            end
          end
          default: begin
            // IDLE, BAD or a new START abort the open frame
            emit      = hold_valid_reg;
            emit_last = 1'b1;
            emit_err  = 1'b1;
            err_inc   = 1'b1;
          end
        endcase
      end
      default: begin
        err_inc = 1'b0;
      end
    endcase
  end

  // Frame FSM, hold register and registered payload outputs
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg       <= WAIT_START;
      hold_data_reg   <= '0;
      hold_valid_reg  <= 1'b0;
      hold_sof_reg    <= 1'b0;
      sof_pending_reg <= 1'b0;
      word_cnt_reg    <= '0;
      o_data          <= '0;
      o_valid         <= 1'b0;
      o_sof           <= 1'b0;
      o_last          <= 1'b0;
      o_err           <= 1'b0;
    end else begin
      o_valid <= emit;
      o_sof   <= emit & hold_sof_reg;
      o_last  <= emit & emit_last;
      o_err   <= emit & emit_err;
      if (emit) begin
        o_data <= hold_data_reg;
      end

      case (state_reg)
        WAIT_START: begin
          if (char_class == CHAR_START) begin
            state_reg       <= IN_FRAME;
            hold_valid_reg  <= 1'b0;
            sof_pending_reg <= 1'b1;
            word_cnt_reg    <= '0;
          end
        end
        IN_FRAME: begin
          case (char_class)
            CHAR_DATA: begin
              hold_data_reg   <= i_rx_data;
              hold_valid_reg  <= 1'b1;
              hold_sof_reg    <= sof_pending_reg;
              sof_pending_reg <= 1'b0;
              if (word_cnt_reg != '1) begin
                word_cnt_reg <= word_cnt_reg + 1'b1;
              end
            end
            CHAR_START: begin
              // Restart: the aborted word has been emitted, open a new frame
              hold_valid_reg  <= 1'b0;
              sof_pending_reg <= 1'b1;
              word_cnt_reg    <= '0;
            end
            default: begin
              hold_valid_reg  <= 1'b0;
              sof_pending_reg <= 1'b0;
              state_reg       <= WAIT_START;
            end
          endcase
        end
        default: begin
          state_reg <= WAIT_START;
        end
      endcase
    end
  end

  // Saturating statistics counters and last good frame length
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_frame_cnt <= '0;
      o_err_cnt   <= '0;
      o_frame_len <= '0;
    end else begin
      if (err_inc && (o_err_cnt != '1)) begin
        o_err_cnt <= o_err_cnt + 1'b1;
      end
      if (frame_done) begin
        o_frame_len <= word_cnt_reg;
        if (o_frame_cnt != '1) begin
          o_frame_cnt <= o_frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/rx_frame_checker.md
RX_FRAME_CHECKER -- requirements
Module: rx_frame_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of the data word (multiple of 8, >= 16).
REQ-002 SHALL have parameter IDLE_CODE, default 8'h07, idle control character.
REQ-003 SHALL have parameter START_CODE, default 8'hFB, start character carried in byte 0 (bits 7:0).
REQ-004 SHALL have parameter EOF_CODE, default 8'hFD, terminate character carried in the top byte.
REQ-005 SHALL have parameter CNT_WIDTH, default 16, width of the frame, error and length counters.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port i_rst, input, 1 bit, reset, asynchronous and active-high.
REQ-008 SHALL have port i_rx_data, input, DATA_WIDTH bits, the incoming MII word.
REQ-009 SHALL have port i_rx_ctrl, input, 1 bit: 1 means a control word, 0 means a data word.
REQ-010 SHALL have port o_data, output, DATA_WIDTH bits, the payload word.
REQ-011 SHALL have port o_valid, output, 1 bit, qualifies o_data.
REQ-012 SHALL have port o_sof, output, 1 bit, marks the first payload word of a frame.
REQ-013 SHALL have port o_last, output, 1 bit, marks the final payload word of a frame.
REQ-014 SHALL have port o_err, output, 1 bit: 1 means the frame ended abnormally; valid only with o_last.
REQ-015 SHALL have port o_frame_cnt, output, CNT_WIDTH bits, count of good frames.
REQ-016 SHALL have port o_err_cnt, output, CNT_WIDTH bits, count of protocol errors.
REQ-017 SHALL have port o_frame_len, output, CNT_WIDTH bits, payload word count of the last good frame.

Function
REQ-018 SHALL classify each input word as follows:
  - IDLE: ctrl=1, all bytes IDLE_CODE.
  - START: ctrl=1, byte0=START_CODE, all other bytes IDLE_CODE.
  - TERM: ctrl=1, top byte=EOF_CODE, all other bytes IDLE_CODE.
  - DATA: ctrl=0.
  - BAD: ctrl=1 and none of IDLE, START or TERM.
REQ-019 SHALL implement a two-state FSM, WAIT_START and IN_FRAME; the reset state is WAIT_START.
REQ-020 In WAIT_START: START goes to IN_FRAME; IDLE and DATA stay in WAIT_START, and DATA is discarded with no error; TERM or BAD increments o_err_cnt and stays in WAIT_START.
REQ-021 In IN_FRAME, each DATA word SHALL be captured into a one-word hold register; a held word SHALL be emitted when the next word is sampled (o_valid=1 for one cycle), giving a fixed latency of 2 edges from input sample to output.
REQ-022 The emitted word SHALL carry o_sof=1 iff it is the first DATA word after START.
REQ-023 The emitted word SHALL carry o_last=1 iff the word sampled behind it is not DATA.
REQ-024 In IN_FRAME, TERM SHALL, on the same edge:
  - set o_last=1 and o_err=0 on the held word;
  - increment o_frame_cnt;
  - load o_frame_len with the word count;
  - go to WAIT_START.
REQ-025 In IN_FRAME, IDLE or BAD SHALL:
  - emit the held word with o_last=1 and o_err=1;
  - increment o_err_cnt;
  - go to WAIT_START.
REQ-026 In IN_FRAME, START SHALL abort the open frame exactly as in REQ-025, increment o_err_cnt, and stay in IN_FRAME as a new frame.
REQ-027 START followed directly by TERM (an empty frame) SHALL produce no output, increment o_err_cnt, and leave o_frame_cnt unchanged.
REQ-028 o_frame_cnt and o_err_cnt SHALL saturate at all-ones.
REQ-029 The per-frame word counter SHALL saturate at all-ones; o_frame_len SHALL report the saturated value.
REQ-030 o_sof and o_last SHALL both be 1 for a single-word frame.
REQ-031 o_data SHALL hold its last value when o_valid=0.
REQ-032 o_valid, o_sof, o_last and o_err SHALL all be registered outputs.

Reset
REQ-033 While i_rst=1, the block SHALL asynchronously force:
  - state to WAIT_START;
  - the hold register empty;
  - o_data to 0;
  - o_valid, o_sof, o_last and o_err to 0;
  - o_frame_cnt, o_err_cnt and o_frame_len to 0.
REQ-034 Reset asserted mid-frame SHALL drop the held word silently: no o_last, no count change.
REQ-035 The first word sampled after reset release SHALL be treated as in WAIT_START.

Structure
REQ-036 A shared package mii_pkg SHALL hold the IDLE, START and EOF code constants, the default data width, the FSM state enum and the character-class enum (IDLE, START, TERM, DATA, BAD).
REQ-037 A combinational sub-module rx_char_decode SHALL map (i_rx_data, i_rx_ctrl) to a character class; the FSM, hold register and counters SHALL stay in rx_frame_checker.

Verification
REQ-038 Scenario: IDLE, START, DATA 64'hAAAA_AAAA_AAAA_AAAA, TERM, repeated 3 times. Required response:
  - each word appears once with o_sof=o_last=1 and o_err=0, 2 edges after sampling;
  - o_frame_cnt=3, o_frame_len=1, o_err_cnt=0.
REQ-039 Scenario: START, DATA 1, 2, 3, TERM. Required response:
  - outputs 1 (o_sof), 2, 3 (o_last) on consecutive cycles;
  - o_frame_len=3.
REQ-040 Scenario: START, DATA 1, IDLE. Required response:
  - output 1 with o_last=1 and o_err=1;
  - o_err_cnt=1, o_frame_cnt=0.
REQ-041 Scenario: START, DATA 5, START, DATA 6, TERM. Required response:
  - 5 is emitted with o_last=1 and o_err=1;
  - 6 is emitted with o_sof=o_last=1 and o_err=0;
  - o_frame_cnt=1, o_err_cnt=1.
REQ-042 Scenario: START, TERM, then a BAD word 64'h0707_0707_0707_07FE with ctrl=1 while in WAIT_START. Required response:
  - no o_valid;
  - o_err_cnt=2.
REQ-043 Scenario: assert i_rst after START and DATA 9. Required response:
  - all outputs are 0 immediately;
  - no word is emitted after release;
  - all counters are 0.
